ep_rst_seq: RTL and testbench



---
 rtl/ep_rst_pkg.sv | 28 ++
 rtl/ep_rst_cnt.sv | 46 ++++
 rtl/ep_rst_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ep_rst_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ep_rst_pkg.sv
// -----------------------------------------------------------------------------
// ep_rst_pkg
// Shared definitions for the endpoint reset sequencer:
//   - state_e     : one-hot sequencer state encoding (6 bits)
//   - cnt_width() : width of the shared GAP / WAIT_RDY down-counter, wide
//                   enough to hold the larger of the two load values.
// -----------------------------------------------------------------------------
package ep_rst_pkg;

  localparam int STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 6'b000001,
    GAP      = 6'b000010,
    WAIT_RDY = 6'b000100,
    RUN      = 6'b001000,
    ERR      = 6'b010000,
    FAIL     = 6'b100000
  } state_e;

  // Bits needed to hold max(gap, timeout) as an unsigned value.
  function automatic int cnt_width(input int gap, input int timeout);
    int m;
    m = (gap > timeout) ? gap : timeout;
    return $clog2(m + 1);
  endfunction

endpackage : ep_rst_pkg

// File: rtl/ep_rst_cnt.sv
// -----------------------------------------------------------------------------
// ep_rst_cnt
// Loadable down-counter shared by the GAP and WAIT_RDY phases of the reset
// sequencer. A load takes priority over a decrement; the count never wraps
// below zero.
//
// Ports:
//   clk250    in   clock, rising edge
//   rst250    in   synchronous active-high reset (count -> 0)
//   load      in   load load_val on the next edge
//   load_val  in   value to load
//   dec       in   decrement by one on the next edge (ignored at zero)
//   zero      out  count == 0
//   one       out  count == 1 (last cycle of the current phase)
// -----------------------------------------------------------------------------
module ep_rst_cnt #(
  parameter int W = 4
) (
  input  logic         clk250,
  input  logic         rst250,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours; blocking here would create order-
  // dependent simulation and a mismatch with the synthesised flops.
  always_ff @(posedge clk250) begin
    if (rst250) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule : ep_rst_cnt

// File: rtl/ep_rst_seq.sv
// -----------------------------------------------------------------------------
// ep_rst_seq
// Consumer end of the endpoint reset chain. Once the PCIe link is up, the
// downstream reset domains are released one at a time in ascending index
// order. Each release is preceded by STAGE_GAP idle cycles and followed by a
// wait (bounded by TIMEOUT cycles) for that stage to report ready. A timeout
// or a ready drop while running restarts the sequence, up to MAX_RETRY times,
// after which the sequencer parks in FAIL with a sticky error. Loss of link
// simply restarts the sequence without counting as a retry.
//
// Ports:
//   clk250        in   250 MHz clock, rising edge
//   rst250        in   synchronous active-high reset, highest priority
//   trn_lnk_up_n  in   PCIe link up, active low
//   stage_rdy     in   per-stage "initialised" level from each domain
//   stage_rst     out  per-stage reset, active high (registered)
//   all_up        out  every stage released and ready (registered)
//   seq_err       out  sticky fatal flag, cleared only by rst250
//   retry_cnt     out  restarts taken since rst250, saturating
// -----------------------------------------------------------------------------
module ep_rst_seq
  import ep_rst_pkg::*;
#(
  parameter int N_STAGES  = 4,
  parameter int STAGE_GAP = 16,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3
) (
  input  logic                             clk250,
  input  logic                             rst250,
  input  logic                             trn_lnk_up_n,
  input  logic [N_STAGES-1:0]              stage_rdy,
  output logic [N_STAGES-1:0]              stage_rst,
  output logic                             all_up,
  output logic                             seq_err,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

  localparam int CW = cnt_width(STAGE_GAP, TIMEOUT);
  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] GAP_LD    = CW'(STAGE_GAP);
  localparam logic [CW-1:0] TO_LD     = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_STAGES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] stage_rst_d;
  logic                all_up_d;
  logic                seq_err_d;
  logic [RW-1:0]       retry_d;

  logic                cnt_load;
  logic [CW-1:0]       cnt_load_val;
  logic                cnt_dec;
  logic                cnt_zero;
  logic                cnt_one;
  logic                cnt_last;

  logic                go_idle;
  logic                go_err;

  ep_rst_cnt #(
    .W (CW)
  ) u_cnt (
    .clk250   (clk250),
    .rst250   (rst250),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  // Final cycle of a GAP or WAIT_RDY phase. The zero term only guards against
  // a phase entered without a load; in normal operation one is hit first.
  assign cnt_last = cnt_one | cnt_zero;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stage_rst_d  = stage_rst;
    all_up_d     = all_up;
    seq_err_d    = seq_err;
    retry_d      = retry_cnt;
    cnt_load     = 1'b0;
    cnt_load_val = GAP_LD;
    cnt_dec      = 1'b0;
    go_idle      = 1'b0;
    go_err       = 1'b0;

    case (state_q)
      IDLE: begin
        stage_rst_d = '1;
        all_up_d    = 1'b0;
        idx_d       = '0;
        if (!trn_lnk_up_n) begin
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LD;
          state_d      = GAP;
        end
      end

      GAP: begin
        if (trn_lnk_up_n) begin
          go_idle = 1'b1;
        end else if (cnt_last) begin
          // Only the current index is ever cleared, so releases are strictly
          // ascending and never skip a lower stage.
          stage_rst_d[idx_q] = 1'b0;
          cnt_load           = 1'b1;
          cnt_load_val       = TO_LD;
          state_d            = WAIT_RDY;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      WAIT_RDY: begin
        // Only the stage just released is looked at; ready levels of stages
        // still in reset are ignored. Ready is checked before the timeout so
        // it wins when both land in the same cycle.
        if (trn_lnk_up_n) begin
          go_idle = 1'b1;
        end else if (stage_rdy[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            all_up_d = 1'b1;
            state_d  = RUN;
          end else begin
            idx_d        = idx_q + 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LD;
            state_d      = GAP;
          end
        end else if (cnt_last) begin
          go_err = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      RUN: begin
        if (trn_lnk_up_n) begin
          go_idle = 1'b1;
        end else if (!(&stage_rdy)) begin
          go_err = 1'b1;
        end
      end

      ERR: begin
        stage_rst_d = '1;
        all_up_d    = 1'b0;
        idx_d       = '0;
        if (retry_cnt == RETRY_MAX) begin
          seq_err_d = 1'b1;
          state_d   = FAIL;
        end else begin
          retry_d = retry_cnt + 1'b1;
          state_d = IDLE;
        end
      end

      FAIL: begin
        // Terminal until rst250; link events are deliberately ignored.
        stage_rst_d = '1;
        all_up_d    = 1'b0;
        seq_err_d   = 1'b1;
      end

      default: begin
        stage_rst_d = '1;
        all_up_d    = 1'b0;
        idx_d       = '0;
        state_d     = IDLE;
      end
    endcase

    // Aborts re-assert every reset on the same edge that leaves the active
    // state, so no downstream domain sees an extra cycle of release.
    if (go_idle || go_err) begin
      stage_rst_d = '1;
      all_up_d    = 1'b0;
      idx_d       = '0;
      state_d     = go_err ? ERR : IDLE;
    end
  end

  always_ff @(posedge clk250) begin
    if (rst250) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stage_rst <= '1;
      all_up    <= 1'b0;
      seq_err   <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stage_rst <= stage_rst_d;
      all_up    <= all_up_d;
      seq_err   <= seq_err_d;
      retry_cnt <= retry_d;
    end
  end

endmodule : ep_rst_seq

// File: tb/tb_ep_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_ep_rst_seq
// Directed bench for ep_rst_seq with STAGE_GAP=4, TIMEOUT=8, N_STAGES=4,
// MAX_RETRY=3. cyc counts rising edges; inputs are driven and outputs sampled
// 1 time unit after each edge, so "cycle c" is the interval after edge c.
// With these parameters a stage released in cycle t accepts ready no earlier
// than t, and the next stage is released 5 cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_ep_rst_seq;

  localparam int N_ST = 4;
  localparam int G    = 4;
  localparam int T    = 8;
  localparam int R    = 3;

  logic            clk250       = 1'b0;
  logic            rst250       = 1'b1;
  logic            trn_lnk_up_n = 1'b1;
  logic [N_ST-1:0] stage_rdy    = '0;
  logic [N_ST-1:0] stage_rst;
  logic            all_up;
  logic            seq_err;
  logic [1:0]      retry_cnt;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_mis  = 0;

  ep_rst_seq #(
    .N_STAGES  (N_ST),
    .STAGE_GAP (G),
    .TIMEOUT   (T),
    .MAX_RETRY (R)
  ) dut (
    .clk250       (clk250),
    .rst250       (rst250),
    .trn_lnk_up_n (trn_lnk_up_n),
    .stage_rdy    (stage_rdy),
    .stage_rst    (stage_rst),
    .all_up       (all_up),
    .seq_err      (seq_err),
    .retry_cnt    (retry_cnt)
  );

  always #2 clk250 = ~clk250;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk250);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 4000) begin
      tick();
      guard++;
    end
  endtask

  // Stimulus only: raises stage_rdy[i] three cycles after each scheduled
  // release, starting from the IDLE cycle n0 that samples link up. Returns in
  // the first cycle all_up should be high.
  task automatic drive_bring_up(input int n0);
    for (int i = 0; i < N_ST; i++) begin
      tick_to(n0 + 8 + 8 * i);
      stage_rdy[i] = 1'b1;
    end
    tick_to(n0 + 33);
  endtask

  task automatic test_reset();
    rst250 = 1'b1; trn_lnk_up_n = 1'b1; stage_rdy = '0;
    tick(); tick();
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL reset_stage_rst: got %h expected %h", stage_rst, 4'hF); end
    n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL reset_all_up: got %b expected 0", all_up); end
    n_cmp++; if (seq_err !== 1'b0) begin n_mis++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    rst250 = 1'b0;
    repeat (6) tick();
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL idle_link_down: got %h expected %h", stage_rst, 4'hF); end
  endtask

  task automatic test_nominal();
    int n0, acc, t_fall;
    logic [3:0] full, exp_b, exp_a;
    full = 4'hF;
    rst250 = 1'b1; trn_lnk_up_n = 1'b0; stage_rdy = '0;
    tick();
    rst250 = 1'b0;
    n0  = cyc;
    acc = n0;
    for (int i = 0; i < N_ST; i++) begin
      t_fall = acc + G + 1;
      exp_b  = full << i;
      exp_a  = full << (i + 1);
      tick_to(t_fall - 1);
      n_cmp++; if (stage_rst !== exp_b) begin n_mis++; $display("FAIL nominal_before_rel%0d: got %h expected %h", i, stage_rst, exp_b); end
      tick();
      n_cmp++; if (stage_rst !== exp_a) begin n_mis++; $display("FAIL nominal_rel%0d: got %h expected %h at cycle %0d", i, stage_rst, exp_a, cyc); end
      n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL nominal_all_up_early%0d: got %b expected 0", i, all_up); end
      tick_to(t_fall + 3);
      stage_rdy[i] = 1'b1;
      acc = cyc;
    end
    tick();
    n_cmp++; if (all_up !== 1'b1) begin n_mis++; $display("FAIL nominal_all_up: got %b expected 1", all_up); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL nominal_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_link_flap();
    int n0;
    trn_lnk_up_n = 1'b1;
    tick();
    trn_lnk_up_n = 1'b0;
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL flap_stage_rst: got %h expected %h", stage_rst, 4'hF); end
    n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL flap_all_up: got %b expected 0", all_up); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL flap_retry: got %0d expected 0", retry_cnt); end
    n_cmp++; if (seq_err !== 1'b0) begin n_mis++; $display("FAIL flap_seq_err: got %b expected 0", seq_err); end
    stage_rdy = '0;
    n0 = cyc;
    drive_bring_up(n0);
    n_cmp++; if (all_up !== 1'b1) begin n_mis++; $display("FAIL flap_rebringup_all_up: got %b expected 1", all_up); end
    n_cmp++; if (stage_rst !== 4'h0) begin n_mis++; $display("FAIL flap_rebringup_stage_rst: got %h expected 0", stage_rst); end
  endtask

  task automatic test_ready_drop();
    int n0;
    stage_rdy[2] = 1'b0;
    tick(); tick();
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL drop_stage_rst: got %h expected %h", stage_rst, 4'hF); end
    n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL drop_all_up: got %b expected 0", all_up); end
    n_cmp++; if (retry_cnt !== 2'd1) begin n_mis++; $display("FAIL drop_retry: got %0d expected 1", retry_cnt); end
    n_cmp++; if (seq_err !== 1'b0) begin n_mis++; $display("FAIL drop_seq_err: got %b expected 0", seq_err); end
    stage_rdy = '0;
    n0 = cyc;
    tick_to(n0 + 4);
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL drop_restart_gap: got %h expected %h", stage_rst, 4'hF); end
    tick();
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL drop_restart_rel0: got %h expected %h", stage_rst, 4'hE); end
    drive_bring_up(n0);
    n_cmp++; if (all_up !== 1'b1) begin n_mis++; $display("FAIL drop_rebringup_all_up: got %b expected 1", all_up); end
    n_cmp++; if (retry_cnt !== 2'd1) begin n_mis++; $display("FAIL drop_rebringup_retry: got %0d expected 1", retry_cnt); end
  endtask

  task automatic test_coincidence();
    int n0;
    rst250 = 1'b1; stage_rdy = 4'b1000;
    tick();
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL midrun_reset_retry: got %0d expected 0", retry_cnt); end
    rst250 = 1'b0;
    n0 = cyc;
    tick_to(n0 + 4);
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL early_gap0: got %h expected %h", stage_rst, 4'hF); end
    tick();
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL early_rel0: got %h expected %h", stage_rst, 4'hE); end
    // Last WAIT_RDY cycle of stage 0: ready and timeout coincide.
    tick_to(n0 + 12);
    stage_rdy[0] = 1'b1;
    tick();
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL coinc_no_err: got %h expected %h", stage_rst, 4'hE); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL coinc_retry: got %0d expected 0", retry_cnt); end
    tick_to(n0 + 16);
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL coinc_gap1: got %h expected %h", stage_rst, 4'hE); end
    tick();
    n_cmp++; if (stage_rst !== 4'hC) begin n_mis++; $display("FAIL coinc_rel1: got %h expected %h", stage_rst, 4'hC); end
    tick_to(n0 + 20);
    stage_rdy[1] = 1'b1;
    tick_to(n0 + 24);
    n_cmp++; if (stage_rst !== 4'hC) begin n_mis++; $display("FAIL early_gap2: got %h expected %h", stage_rst, 4'hC); end
    tick();
    n_cmp++; if (stage_rst !== 4'h8) begin n_mis++; $display("FAIL early_rel2: got %h expected %h", stage_rst, 4'h8); end
    tick_to(n0 + 28);
    stage_rdy[2] = 1'b1;
    tick_to(n0 + 32);
    n_cmp++; if (stage_rst !== 4'h8) begin n_mis++; $display("FAIL early_gap3: got %h expected %h", stage_rst, 4'h8); end
    tick();
    n_cmp++; if (stage_rst !== 4'h0) begin n_mis++; $display("FAIL early_rel3: got %h expected 0", stage_rst); end
    n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL early_all_up_soon: got %b expected 0", all_up); end
    tick();
    n_cmp++; if (all_up !== 1'b1) begin n_mis++; $display("FAIL early_all_up: got %b expected 1", all_up); end
  endtask

  task automatic test_timeout();
    int n0, m, n1;
    rst250 = 1'b1; stage_rdy = '0;
    tick();
    rst250 = 1'b0;
    n0 = cyc;
    tick_to(n0 + 8);
    stage_rdy[0] = 1'b1;
    m = n0 + 13;
    tick_to(m - 1);
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL to_gap1: got %h expected %h", stage_rst, 4'hE); end
    tick();
    n_cmp++; if (stage_rst !== 4'hC) begin n_mis++; $display("FAIL to_rel1: got %h expected %h", stage_rst, 4'hC); end
    tick_to(m + 7);
    n_cmp++; if (stage_rst !== 4'hC) begin n_mis++; $display("FAIL to_last_wait: got %h expected %h", stage_rst, 4'hC); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL to_retry_before: got %0d expected 0", retry_cnt); end
    tick_to(m + 9);
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL to_stage_rst: got %h expected %h", stage_rst, 4'hF); end
    n_cmp++; if (retry_cnt !== 2'd1) begin n_mis++; $display("FAIL to_retry: got %0d expected 1", retry_cnt); end
    stage_rdy = '0;
    n1 = cyc;
    tick_to(n1 + 4);
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL to_restart_gap: got %h expected %h", stage_rst, 4'hF); end
    tick();
    n_cmp++; if (stage_rst !== 4'hE) begin n_mis++; $display("FAIL to_restart_rel0: got %h expected %h", stage_rst, 4'hE); end
  endtask

  task automatic test_fatal();
    int n0;
    logic [1:0] exp_r;
    logic       exp_e;
    rst250 = 1'b1; stage_rdy = '0; trn_lnk_up_n = 1'b0;
    tick();
    rst250 = 1'b0;
    n0 = cyc;
    for (int a = 0; a <= R; a++) begin
      exp_r = (a < R) ? 2'(a + 1) : 2'(R);
      exp_e = (a == R);
      tick_to(n0 + 8);
      stage_rdy[0] = 1'b1;
      tick_to(n0 + 16);
      stage_rdy[1] = 1'b1;
      tick_to(n0 + 21);
      n_cmp++; if (stage_rst !== 4'h8) begin n_mis++; $display("FAIL fatal_rel2_try%0d: got %h expected %h", a, stage_rst, 4'h8); end
      tick_to(n0 + 30);
      n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL fatal_stage_rst_try%0d: got %h expected %h", a, stage_rst, 4'hF); end
      n_cmp++; if (retry_cnt !== exp_r) begin n_mis++; $display("FAIL fatal_retry_try%0d: got %0d expected %0d", a, retry_cnt, exp_r); end
      n_cmp++; if (seq_err !== exp_e) begin n_mis++; $display("FAIL fatal_seq_err_try%0d: got %b expected %b", a, seq_err, exp_e); end
      stage_rdy = '0;
      n0 = cyc;
    end
    trn_lnk_up_n = 1'b1;
    tick(); tick();
    trn_lnk_up_n = 1'b0;
    repeat (12) tick();
    stage_rdy = 4'hF;
    repeat (3) tick();
    n_cmp++; if (stage_rst !== 4'hF) begin n_mis++; $display("FAIL fail_hold_stage_rst: got %h expected %h", stage_rst, 4'hF); end
    n_cmp++; if (seq_err !== 1'b1) begin n_mis++; $display("FAIL fail_hold_seq_err: got %b expected 1", seq_err); end
    n_cmp++; if (all_up !== 1'b0) begin n_mis++; $display("FAIL fail_hold_all_up: got %b expected 0", all_up); end
    n_cmp++; if (retry_cnt !== 2'd3) begin n_mis++; $display("FAIL fail_hold_retry: got %0d expected 3", retry_cnt); end
    rst250 = 1'b1;
    tick();
    n_cmp++; if (seq_err !== 1'b0) begin n_mis++; $display("FAIL fail_clear_seq_err: got %b expected 0", seq_err); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_mis++; $display("FAIL fail_clear_retry: got %0d expected 0", retry_cnt); end
    rst250 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_link_flap();
    test_ready_drop();
    test_coincidence();
    test_timeout();
    test_fatal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_ep_rst_seq
